// File: rtl/mpmc11_rd_strip_collect.sv
// mpmc11_rd_strip_collect
//
// Collects the read-data beats of one multi-strip read request into a
// full-width line buffer. Each beat fills one strip. A one-cycle done pulse
// tells the port read-return logic that line_data is complete.
//
// Optional feature: define MPMC11_RD_STRIP_TIMEOUT_EN to add a watchdog.
// The watchdog aborts a collection after TIMEOUT cycles without a beat and
// pulses timeout. When the macro is undefined, timeout is tied low and a
// collection waits indefinitely.
//
// Ports:
//   clk           system clock
//   rst           asynchronous active-high reset
//   start         one-cycle pulse; begin collecting a new read
//   num_strips    last strip index of the request (strip count = num_strips+1)
//   rd_data_valid app read data valid
//   rd_data       app read data beat (one strip)
//   line_data     assembled line, strip i in bits [i*DATA_WIDTH +: DATA_WIDTH]
//   strip_cnt     index of the next strip to be filled
//   busy          collection in progress
//   done          one-cycle pulse; line_data complete and valid
//   err           sticky: num_strips clamped or stray beat seen; cleared by start
//   timeout       one-cycle pulse; request aborted by the watchdog
module mpmc11_rd_strip_collect #(
  parameter int unsigned DATA_WIDTH = 128,
  parameter int unsigned MAX_STRIPS = 4,
  parameter int unsigned TIMEOUT    = 255
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic                             start,
  input  logic [7:0]                       num_strips,
  input  logic                             rd_data_valid,
  input  logic [DATA_WIDTH-1:0]            rd_data,
  output logic [DATA_WIDTH*MAX_STRIPS-1:0] line_data,
  output logic [7:0]                       strip_cnt,
  output logic                             busy,
  output logic                             done,
  output logic                             err,
  output logic                             timeout
);

  localparam int unsigned LaneW   = (MAX_STRIPS > 1) ? $clog2(MAX_STRIPS) : 1;
  localparam logic [7:0]  MaxLast = 8'(MAX_STRIPS - 1);

  typedef enum logic [1:0] {StIdle, StCollect, StDone} state_e;

  state_e                          state_q, state_d;
  logic [7:0]                      last_q, last_d;
  logic [DATA_WIDTH*MAX_STRIPS-1:0] line_q, line_d;
  logic [7:0]                      cnt_q, cnt_d;
  logic                            busy_q, busy_d;
  logic                            done_q, done_d;
  logic                            err_q, err_d;
  logic [LaneW-1:0]                lane;
  logic                            wd_fire;

  // strip_cnt never exceeds last < MAX_STRIPS, so its low bits select the lane.
  assign lane = cnt_q[LaneW-1:0];

`ifdef MPMC11_RD_STRIP_TIMEOUT_EN
  localparam int unsigned WdW = $clog2(TIMEOUT + 1);

  logic [WdW-1:0] wd_q, wd_d;
  logic           timeout_q;

  // Counts idle COLLECT cycles; any accepted beat or leaving COLLECT clears it.
  // A beat in the cycle the count would reach TIMEOUT wins over the abort.
  assign wd_fire = (state_q == StCollect) && !rd_data_valid && (wd_q == WdW'(TIMEOUT - 1));

  always_comb begin
    wd_d = '0;
    if (state_q == StCollect && !rd_data_valid && !wd_fire) begin
      wd_d = wd_q + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wd_q      <= '0;
      timeout_q <= 1'b0;
    end else begin
      wd_q      <= wd_d;
      timeout_q <= wd_fire;
    end
  end

  assign timeout = timeout_q;
`else
  logic unused_timeout_cfg;

  assign unused_timeout_cfg = (TIMEOUT != 0);
  assign wd_fire            = 1'b0;
  assign timeout            = 1'b0;
`endif

  always_comb begin
    state_d = state_q;
    last_d  = last_q;
    line_d  = line_q;
    cnt_d   = cnt_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    err_d   = err_q;

    unique case (state_q)
      StIdle: begin
        if (start) begin
          last_d  = (num_strips > MaxLast) ? MaxLast : num_strips;
          line_d  = '0;
          cnt_d   = '0;
          // A beat coinciding with start is dropped and flagged as stray.
          err_d   = (num_strips > MaxLast) || rd_data_valid;
          busy_d  = 1'b1;
          state_d = StCollect;
        end else if (rd_data_valid) begin
          err_d = 1'b1;
        end
      end

      StCollect: begin
        if (rd_data_valid) begin
          for (int i = 0; i < int'(MAX_STRIPS); i++) begin
            if (int'(lane) == i) begin
              line_d[i*DATA_WIDTH +: DATA_WIDTH] = rd_data;
            end
          end
          if (cnt_q != last_q) begin
            cnt_d = cnt_q + 8'd1;
          end else begin
            busy_d  = 1'b0;
            done_d  = 1'b1;
            state_d = StDone;
          end
        end else if (wd_fire) begin
          busy_d  = 1'b0;
          state_d = StIdle;
        end
      end

      StDone: begin
        state_d = StIdle;
        if (rd_data_valid) begin
          err_d = 1'b1;
        end
      end

      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= StIdle;
      last_q  <= '0;
      line_q  <= '0;
      cnt_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      last_q  <= last_d;
      line_q  <= line_d;
      cnt_q   <= cnt_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      err_q   <= err_d;
    end
  end

  assign line_data = line_q;
  assign strip_cnt = cnt_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign err       = err_q;

endmodule

// File: tb/tb_mpmc11_rd_strip_collect.sv
// Self-checking bench for mpmc11_rd_strip_collect (DATA_WIDTH=128,
// MAX_STRIPS=4, TIMEOUT=8). Expected values come from a transaction-level
// model: an array of expected lanes, the expected strip count and error flag.
module tb_mpmc11_rd_strip_collect;

  logic         clk;
  logic         rst;
  logic         start;
  logic [7:0]   num_strips;
  logic         rd_data_valid;
  logic [127:0] rd_data;
  logic [511:0] line_data;
  logic [7:0]   strip_cnt;
  logic         busy;
  logic         done;
  logic         err;
  logic         timeout;

  int n_checks = 0;
  int n_errors = 0;

  // Reference model state
  logic [127:0] lanes [4];
  logic         exp_err;

  mpmc11_rd_strip_collect #(
    .DATA_WIDTH(128),
    .MAX_STRIPS(4),
    .TIMEOUT   (8)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .start        (start),
    .num_strips   (num_strips),
    .rd_data_valid(rd_data_valid),
    .rd_data      (rd_data),
    .line_data    (line_data),
    .strip_cnt    (strip_cnt),
    .busy         (busy),
    .done         (done),
    .err          (err),
    .timeout      (timeout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [511:0] got, input logic [511:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got %0h exp %0h", tag, got, exp);
    end
  endtask

  function automatic logic [511:0] exp_line();
    return {lanes[3], lanes[2], lanes[1], lanes[0]};
  endfunction

  function automatic logic [127:0] rand128();
    return {$urandom(), $urandom(), $urandom(), $urandom()};
  endfunction

  // One clock edge with the current inputs; returns 1 time unit after it.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_model();
    for (int i = 0; i < 4; i++) lanes[i] = '0;
    exp_err = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    clear_model();
    check_eq("rst_line", line_data, '0);
    check_eq("rst_cnt", strip_cnt, 8'd0);
    check_eq("rst_busy", busy, 1'b0);
    check_eq("rst_done", done, 1'b0);
    check_eq("rst_err", err, 1'b0);
    check_eq("rst_tmo", timeout, 1'b0);
  endtask

  // Beat while idle: dropped, err set, line untouched.
  task automatic stray_beat();
    rd_data_valid = 1'b1;
    rd_data       = rand128();
    tick();
    rd_data_valid = 1'b0;
    exp_err       = 1'b1;
    check_eq("stray_err", err, exp_err);
    check_eq("stray_line", line_data, exp_line());
    check_eq("stray_busy", busy, 1'b0);
  endtask

  // Full request: start (optionally with a coinciding beat), beats with random
  // gaps (optionally with ignored start pulses), optional beat in the done cycle.
  task automatic run_req(input logic [7:0] ns, input int gap_max, input bit overlap,
                         input bit mid_start, input bit extra);
    int n;
    n = (ns > 8'd3) ? 4 : int'(ns) + 1;
    for (int i = 0; i < 4; i++) lanes[i] = '0;
    exp_err       = (ns > 8'd3) || overlap;
    start         = 1'b1;
    num_strips    = ns;
    rd_data_valid = overlap;
    rd_data       = rand128();
    tick();
    start         = 1'b0;
    rd_data_valid = 1'b0;
    check_eq("start_busy", busy, 1'b1);
    check_eq("start_cnt", strip_cnt, 8'd0);
    check_eq("start_err", err, exp_err);
    check_eq("start_line", line_data, '0);
    for (int k = 0; k < n; k++) begin
      int gap;
      gap = (gap_max > 0) ? $urandom_range(0, gap_max) : 0;
      for (int g = 0; g < gap; g++) begin
        tick();
        check_eq("gap_busy", busy, 1'b1);
        check_eq("gap_done", done, 1'b0);
        check_eq("gap_cnt", strip_cnt, 8'(k));
      end
      lanes[k]      = rand128();
      rd_data_valid = 1'b1;
      rd_data       = lanes[k];
      start         = mid_start && ($urandom_range(0, 1) == 1);
      num_strips    = 8'($urandom_range(0, 255));
      tick();
      rd_data_valid = 1'b0;
      start         = 1'b0;
      if (k < n - 1) begin
        check_eq("beat_busy", busy, 1'b1);
        check_eq("beat_done", done, 1'b0);
        check_eq("beat_cnt", strip_cnt, 8'(k + 1));
      end else begin
        check_eq("fin_done", done, 1'b1);
        check_eq("fin_busy", busy, 1'b0);
        check_eq("fin_cnt", strip_cnt, 8'(n - 1));
        check_eq("fin_line", line_data, exp_line());
        check_eq("fin_err", err, exp_err);
      end
    end
    // Cycle in the done state: a beat here is discarded.
    rd_data_valid = extra;
    rd_data       = rand128();
    start         = mid_start;
    tick();
    rd_data_valid = 1'b0;
    start         = 1'b0;
    if (extra) exp_err = 1'b1;
    check_eq("post_done", done, 1'b0);
    check_eq("post_busy", busy, 1'b0);
    check_eq("post_line", line_data, exp_line());
    check_eq("post_err", err, exp_err);
  endtask

  initial begin
    rst           = 1'b1;
    start         = 1'b0;
    num_strips    = '0;
    rd_data_valid = 1'b0;
    rd_data       = '0;
    #2;
    check_eq("async_rst_busy", busy, 1'b0);
    do_reset();

    // 4 strips, back to back
    run_req(8'd3, 0, 1'b0, 1'b0, 1'b0);
    // single strip, beat 5 cycles after start
    begin
      lanes[1] = '0;
      start      = 1'b1;
      num_strips = 8'd0;
      tick();
      start = 1'b0;
      for (int i = 0; i < 4; i++) lanes[i] = '0;
      exp_err = 1'b0;
      repeat (4) begin
        tick();
        check_eq("s1_wait_busy", busy, 1'b1);
      end
      lanes[0]      = rand128();
      rd_data_valid = 1'b1;
      rd_data       = lanes[0];
      tick();
      rd_data_valid = 1'b0;
      check_eq("s1_done", done, 1'b1);
      check_eq("s1_cnt", strip_cnt, 8'd0);
      check_eq("s1_line", line_data, exp_line());
      tick();
      check_eq("s1_done_off", done, 1'b0);
    end
    // clamp with a 5th beat in the done cycle
    run_req(8'd9, 1, 1'b0, 1'b0, 1'b1);
    // stray in idle, start+beat overlap, mid-collect start
    stray_beat();
    run_req(8'd3, 1, 1'b1, 1'b1, 1'b0);

    // reset after 2 of 4 beats
    start      = 1'b1;
    num_strips = 8'd3;
    tick();
    start = 1'b0;
    repeat (2) begin
      rd_data_valid = 1'b1;
      rd_data       = rand128();
      tick();
    end
    rd_data_valid = 1'b0;
    rst = 1'b1;
    #1;
    check_eq("mid_rst_line", line_data, '0);
    check_eq("mid_rst_cnt", strip_cnt, 8'd0);
    check_eq("mid_rst_busy", busy, 1'b0);
    check_eq("mid_rst_done", done, 1'b0);
    do_reset();
    run_req(8'd3, 0, 1'b0, 1'b0, 1'b0);

    // watchdog: 2 beats then silence
    start      = 1'b1;
    num_strips = 8'd3;
    tick();
    start = 1'b0;
    for (int k = 0; k < 2; k++) begin
      lanes[k]      = rand128();
      rd_data_valid = 1'b1;
      rd_data       = lanes[k];
      tick();
    end
    rd_data_valid = 1'b0;
`ifdef MPMC11_RD_STRIP_TIMEOUT_EN
    for (int t = 1; t <= 9; t++) begin
      tick();
      check_eq("wd_tmo", timeout, (t == 8) ? 1'b1 : 1'b0);
      check_eq("wd_busy", busy, (t >= 8) ? 1'b0 : 1'b1);
      check_eq("wd_done", done, 1'b0);
      check_eq("wd_cnt", strip_cnt, 8'd2);
    end
    check_eq("wd_line", line_data, exp_line());
`else
    for (int t = 1; t <= 20; t++) begin
      tick();
      check_eq("nowd_tmo", timeout, 1'b0);
      check_eq("nowd_busy", busy, 1'b1);
      check_eq("nowd_cnt", strip_cnt, 8'd2);
    end
`endif
    do_reset();

    // randomized requests
    for (int r = 0; r < 40; r++) begin
      if ($urandom_range(0, 3) == 0) stray_beat();
      run_req(8'($urandom_range(0, 9)), 3, ($urandom_range(0, 4) == 0),
              ($urandom_range(0, 1) == 1), ($urandom_range(0, 3) == 0));
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/mpmc11_rd_strip_collect.md
Name: mpmc11_rd_strip_collect

Overview:
- Downstream consumer of the controller's read strip sequencing.
- Gathers the read-data beats returned by the DRAM app interface for one multi-strip read request, one beat per strip, into a full-width line buffer.
- Signals completion to the port read-return logic.
- Sits between the app-interface read data path and the per-port read FIFOs.

Parameters:
- DATA_WIDTH, 128, width of one app read beat (one strip).
- MAX_STRIPS, 4, capacity of the line buffer in strips. Line width = DATA_WIDTH*MAX_STRIPS.
- TIMEOUT, 255, cycles without a beat before abort. Used only with the optional feature.

Ports:
- clk  input  1  system clock.
- rst  input  1  asynchronous active-high reset.
- start  input  1  one-cycle pulse; begin collecting a new read.
- num_strips  input  8  last strip index for the request (strip count = num_strips+1).
- rd_data_valid  input  1  app read data valid.
- rd_data  input  DATA_WIDTH  app read data beat.
- line_data  output  DATA_WIDTH*MAX_STRIPS  assembled line.
- strip_cnt  output  8  index of next strip to be filled.
- busy  output  1  collection in progress.
- done  output  1  one-cycle pulse; line_data complete and valid.
- err  output  1  sticky: num_strips clamped or stray beat seen; cleared by start.
- timeout  output  1  one-cycle pulse; request aborted (optional feature).

Behaviour:
- Clock and reset: one clock; reset is asynchronous and active-high.
- Reset values: line_data=0, strip_cnt=0, busy=0, done=0, err=0, timeout=0. State=IDLE, latched last index=0.
- FSM states: IDLE, COLLECT, DONE.
- IDLE:
  - start: latch last=min(num_strips, MAX_STRIPS-1); clear line_data to 0; strip_cnt<=0; err<=(num_strips>MAX_STRIPS-1); busy<=1; go COLLECT.
  - rd_data_valid without start: beat discarded, err<=1.
  - start and rd_data_valid in the same cycle: start wins; the beat is discarded and sets err.
- COLLECT:
  - Each rd_data_valid cycle: line_data[strip_cnt*DATA_WIDTH +: DATA_WIDTH]<=rd_data.
  - If strip_cnt!=last: strip_cnt<=strip_cnt+1.
  - Else: go DONE, busy<=0, done<=1 registered (visible the cycle after the final beat). strip_cnt holds at last.
  - No back-pressure: a beat is accepted every valid cycle, including back-to-back beats.
  - start is ignored while in COLLECT.
- DONE: lasts one cycle.
  - done deasserts and the FSM returns to IDLE.
  - line_data holds until the next start.
  - rd_data_valid in DONE is discarded and sets err.
  - start in DONE is ignored.
- Latency:
  - Final beat to done: 1 cycle.
  - Minimum start to done for N strips: N+1 cycles, with beats arriving from the cycle after start.
- Width rules:
  - strip_cnt is 8 bits, but it is bounded by last < MAX_STRIPS, so it never wraps.
  - Lane select uses the low $clog2(MAX_STRIPS) bits of strip_cnt (minimum 1 bit).
- Asynchronous reset mid-collection: immediate return to reset values. No done is produced and partial data is lost.

Optional Feature:
- Macro: MPMC11_RD_STRIP_TIMEOUT_EN.
- Defined: a watchdog counter of width $clog2(TIMEOUT+1) runs in COLLECT.
  - It clears on start and on each accepted beat.
  - When it reaches TIMEOUT with no beat: timeout pulses 1 cycle, busy<=0, FSM returns to IDLE, done is not asserted. line_data keeps the partial contents and strip_cnt holds.
  - A beat arriving in the same cycle the count reaches TIMEOUT is accepted; that cycle is not a timeout.
- Undefined: no watchdog logic; timeout tied 0. COLLECT waits indefinitely.

Test Plan:
1. 4-strip read:
   - Stimulus: start with num_strips=3, then beats 0x11..,0x22..,0x33..,0x44.. back-to-back.
   - Response: line_data lanes 0..3 match in order; done pulses exactly once, 1 cycle after the 4th beat; busy high for 4 cycles; err=0.
2. Single strip with gaps:
   - Stimulus: num_strips=0; beat arrives 5 cycles after start.
   - Response: lane 0 written, lanes 1..3 read as 0; done one cycle after the beat; strip_cnt=0.
3. Clamp:
   - Stimulus: num_strips=9 with MAX_STRIPS=4.
   - Response: err=1; done after exactly 4 beats; a 5th beat is discarded, line_data unchanged, err stays 1.
4. Stray and overlap:
   - Stimulus: beat in IDLE; then start and a beat in the same cycle; then start pulsed again mid-COLLECT.
   - Response: err=1 in both stray cases; the mid-COLLECT start is ignored and strip_cnt is not reset.
5. Reset mid-op:
   - Stimulus: assert rst after 2 of 4 beats.
   - Response: all outputs 0 asynchronously, no done; a new start then behaves as in test 1.
6. Timeout (with MPMC11_RD_STRIP_TIMEOUT_EN, TIMEOUT=8):
   - Stimulus: num_strips=3; 2 beats, then silence.
   - Response: timeout pulses 8 cycles after the 2nd beat; done never asserts; strip_cnt=2; busy=0.
   - Repeat without the macro: busy remains 1 and timeout stays 0.
